// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between an
// instruction-fetch port and a load/store port; one transaction in flight.

module mem_port_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_valid,
  output logic [31:0] ls_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  state_t     state_r;
  logic [2:0] cnt_r;
  logic       owner_ls_r;
  logic       last_ls_r;
  logic       we_r;
  logic       ls_win_s;

  // LS wins when alone, or on a tie when IF was the last one served
  assign ls_win_s = ls_req & (~if_req | ~last_ls_r);

  // Transaction FSM with all outputs registered
  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      owner_ls_r <= 1'b0;
      last_ls_r  <= 1'b0;
      we_r       <= 1'b0;
      if_gnt     <= 1'b0;
      if_valid   <= 1'b0;
      if_rdata   <= 32'h0000_0000;
      ls_gnt     <= 1'b0;
      ls_valid   <= 1'b0;
      ls_rdata   <= 32'h0000_0000;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0000_0000;
      mem_wdata  <= 32'h0000_0000;
      busy       <= 1'b0;
    end else begin
      if_gnt   <= 1'b0;
      ls_gnt   <= 1'b0;
      if_valid <= 1'b0;
      ls_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (if_req || ls_req) begin
            owner_ls_r <= ls_win_s;
            last_ls_r  <= ls_win_s;
            we_r       <= ls_win_s & ls_we;
            mem_we     <= ls_win_s & ls_we;
            mem_addr   <= ls_win_s ? ls_addr : if_addr;
            mem_wdata  <= ls_win_s ? ls_wdata : mem_wdata;
            mem_en     <= 1'b1;
            if_gnt     <= ~ls_win_s;
            ls_gnt     <= ls_win_s;
            cnt_r      <= LAT_LOAD;
            busy       <= 1'b1;
            state_r    <= ACCESS;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (cnt_r == 3'd0) begin
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            state_r <= WAIT;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        WAIT: begin
          // Stores leave both read-data registers untouched
          if (!we_r) begin
            if (owner_ls_r) begin
              ls_rdata <= mem_rdata;
            end else begin
              if_rdata <= mem_rdata;
            end
          end else begin
            ls_rdata <= ls_rdata;
          end
          if_valid <= ~owner_ls_r;
          ls_valid <= owner_ls_r;
          state_r  <= RESP;
        end
        RESP: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  mem_port_arbiter_chk u_chk (
    .CLK      (CLK),
    .rst      (rst),
    .if_gnt   (if_gnt),
    .ls_gnt   (ls_gnt),
    .if_valid (if_valid),
    .ls_valid (ls_valid),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .busy     (busy)
  );

endmodule

// Structural invariants of the arbiter outputs.
module mem_port_arbiter_chk (
  input logic CLK,
  input logic rst,
  input logic if_gnt,
  input logic ls_gnt,
  input logic if_valid,
  input logic ls_valid,
  input logic mem_en,
  input logic mem_we,
  input logic busy
);

  a_we_needs_en:     assert property (@(posedge CLK) disable iff (!rst) mem_we |-> mem_en);
  a_gnt_onehot:      assert property (@(posedge CLK) disable iff (!rst) !(if_gnt && ls_gnt));
  a_valid_onehot:    assert property (@(posedge CLK) disable iff (!rst) !(if_valid && ls_valid));
  a_gnt_with_en:     assert property (@(posedge CLK) disable iff (!rst) (if_gnt || ls_gnt) |-> mem_en);
  a_en_implies_busy: assert property (@(posedge CLK) disable iff (!rst) mem_en |-> busy);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=1 and MEM_LAT=3 instances,
// read data checked through per-port expectation queues.

module tb_mem_port_arbiter;

  logic        CLK;
  logic        rst;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic        if_gnt, if_valid, ls_gnt, ls_valid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;

  logic        d3_if_req, d3_ls_req, d3_ls_we;
  logic [31:0] d3_if_addr, d3_ls_addr, d3_ls_wdata, d3_mem_rdata;
  logic        d3_if_gnt, d3_if_valid, d3_ls_gnt, d3_ls_valid, d3_mem_en, d3_mem_we, d3_busy;
  logic [31:0] d3_if_rdata, d3_ls_rdata, d3_mem_addr, d3_mem_wdata;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] if_q[$];
  logic [31:0] ls_q[$];
  logic [31:0] d3_q[$];
  logic [31:0] mem_model[0:15];

  mem_port_arbiter #(.MEM_LAT(1)) dut (
    .CLK(CLK), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LAT(3)) dut3 (
    .CLK(CLK), .rst(rst),
    .if_req(d3_if_req), .if_addr(d3_if_addr), .if_gnt(d3_if_gnt), .if_valid(d3_if_valid),
    .if_rdata(d3_if_rdata),
    .ls_req(d3_ls_req), .ls_we(d3_ls_we), .ls_addr(d3_ls_addr), .ls_wdata(d3_ls_wdata),
    .ls_gnt(d3_ls_gnt), .ls_valid(d3_ls_valid), .ls_rdata(d3_ls_rdata),
    .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata),
    .mem_rdata(d3_mem_rdata), .busy(d3_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] d3_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory models: data appears the cycle after an enabled read cycle
  always @(posedge CLK) begin
    mem_rdata    <= (mem_en && !mem_we) ? mem_model[mem_addr[5:2]] : 32'hBAD0_BAD0;
    d3_mem_rdata <= (d3_mem_en && !d3_mem_we) ? d3_fn(d3_mem_addr) : 32'hBAD0_BAD0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard: each valid pulse pops the oldest expectation of its port
  always @(negedge CLK) begin
    if (if_valid === 1'b1) begin
      if (if_q.size() == 0) chk("if_valid_unexpected", {31'd0, if_valid}, 32'd0);
      else chk("if_rdata", if_rdata, if_q.pop_front());
    end
    if (ls_valid === 1'b1) begin
      if (ls_q.size() == 0) chk("ls_valid_unexpected", {31'd0, ls_valid}, 32'd0);
      else chk("ls_rdata", ls_rdata, ls_q.pop_front());
    end
    if (d3_ls_valid === 1'b1) begin
      if (d3_q.size() == 0) chk("d3_ls_valid_unexpected", {31'd0, d3_ls_valid}, 32'd0);
      else chk("d3_ls_rdata", d3_ls_rdata, d3_q.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem_model[i] = 32'h1000_0000 + 32'(i) * 32'h0000_0101;
    mem_model[2] = 32'h8C25_0003;
    rst = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'd0; ls_wdata = 32'd0;
    d3_if_req = 1'b0; d3_if_addr = 32'd0;
    d3_ls_req = 1'b0; d3_ls_we = 1'b0; d3_ls_addr = 32'd0; d3_ls_wdata = 32'd0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_ctrl", {25'd0, if_gnt, if_valid, ls_gnt, ls_valid, mem_en, mem_we, busy}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    chk("rst_d3_busy", {31'd0, d3_busy}, 32'd0);
    rst = 1'b1;
    tick();

    // Single fetch, MEM_LAT=1
    if_req = 1'b1; if_addr = 32'h0000_0008;
    if_q.push_back(32'h8C25_0003);
    tick();
    chk("fetch_c1_gnt", {30'd0, if_gnt, ls_gnt}, 32'd2);
    chk("fetch_c1_en_we", {30'd0, mem_en, mem_we}, 32'd2);
    chk("fetch_c1_addr", mem_addr, 32'h0000_0008);
    chk("fetch_c1_busy", {31'd0, busy}, 32'd1);
    if_req = 1'b0;
    tick();
    chk("fetch_c2_en", {31'd0, mem_en}, 32'd0);
    chk("fetch_c2_valid", {31'd0, if_valid}, 32'd0);
    tick();
    chk("fetch_c3_valid", {31'd0, if_valid}, 32'd1);
    tick();
    chk("fetch_c4_busy", {31'd0, busy}, 32'd0);
    chk("fetch_c4_valid", {31'd0, if_valid}, 32'd0);

    // Store: ls_rdata must stay at its reset value
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_000C; ls_wdata = 32'h1234_5678;
    ls_q.push_back(32'h0000_0000);
    tick();
    chk("store_c1_gnt", {30'd0, if_gnt, ls_gnt}, 32'd1);
    chk("store_c1_en_we", {30'd0, mem_en, mem_we}, 32'd3);
    chk("store_c1_addr", mem_addr, 32'h0000_000C);
    chk("store_c1_wdata", mem_wdata, 32'h1234_5678);
    ls_req = 1'b0; ls_addr = 32'hFFFF_FFF0; ls_wdata = 32'hFFFF_FFFF;
    tick();
    chk("store_c2_en_we", {30'd0, mem_en, mem_we}, 32'd0);
    chk("store_c2_addr_hold", mem_addr, 32'h0000_000C);
    chk("store_c2_wdata_hold", mem_wdata, 32'h1234_5678);
    tick();
    chk("store_c3_valid", {31'd0, ls_valid}, 32'd1);
    tick();

    // Unaligned load: address passes through bit-exactly
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_001F;
    ls_q.push_back(mem_model[7]);
    tick();
    chk("load_c1_gnt", {30'd0, if_gnt, ls_gnt}, 32'd1);
    chk("load_c1_addr", mem_addr, 32'h0000_001F);
    ls_req = 1'b0;
    tick(); tick();
    chk("load_c3_valid", {31'd0, ls_valid}, 32'd1);
    tick();
    chk("if_rdata_hold", if_rdata, 32'h8C25_0003);

    // Both requests held through reset: LS, IF, LS, IF every 4 cycles
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0010;
    ls_req = 1'b1; ls_addr = 32'h0000_0014; ls_we = 1'b0;
    tick(); tick();
    chk("rst2_ctrl", {25'd0, if_gnt, if_valid, ls_gnt, ls_valid, mem_en, mem_we, busy}, 32'd0);
    chk("rst2_if_rdata", if_rdata, 32'd0);
    chk("rst2_ls_rdata", ls_rdata, 32'd0);
    ls_q.push_back(mem_model[5]); ls_q.push_back(mem_model[5]);
    if_q.push_back(mem_model[4]); if_q.push_back(mem_model[4]);
    rst = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("tie_gnt_k%0d", k), {30'd0, if_gnt, ls_gnt},
          (k == 1 || k == 9) ? 32'd1 : ((k == 5 || k == 13) ? 32'd2 : 32'd0));
      chk($sformatf("tie_en_k%0d", k), {31'd0, mem_en}, {31'd0, (k % 4 == 1)});
    end
    if_req = 1'b0; ls_req = 1'b0;
    tick();

    // Reset during the ACCESS cycle of a load abandons it
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0020;
    tick();
    chk("abort_c1_gnt", {31'd0, ls_gnt}, 32'd1);
    rst = 1'b0; ls_req = 1'b0;
    tick();
    chk("abort_ctrl", {25'd0, if_gnt, if_valid, ls_gnt, ls_valid, mem_en, mem_we, busy}, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    rst = 1'b1;
    tick(); tick(); tick(); tick();
    if_req = 1'b1; if_addr = 32'h0000_0024;
    if_q.push_back(mem_model[9]);
    tick();
    chk("fresh_gnt", {30'd0, if_gnt, ls_gnt}, 32'd2);
    chk("fresh_addr", mem_addr, 32'h0000_0024);
    if_req = 1'b0;
    tick(); tick();
    chk("fresh_valid", {31'd0, if_valid}, 32'd1);
    tick();

    // MEM_LAT=3 single load
    d3_ls_req = 1'b1; d3_ls_addr = 32'h0000_0018;
    d3_q.push_back(d3_fn(32'h0000_0018));
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) begin
        chk("d3_gnt", {28'd0, d3_if_gnt, d3_if_valid, d3_ls_gnt, d3_mem_we}, 32'd2);
        d3_ls_req = 1'b0;
      end
      chk($sformatf("d3_en_k%0d", k), {31'd0, d3_mem_en}, {31'd0, (k <= 3)});
      chk($sformatf("d3_valid_k%0d", k), {31'd0, d3_ls_valid}, {31'd0, (k == 5)});
      chk($sformatf("d3_busy_k%0d", k), {31'd0, d3_busy}, {31'd0, (k <= 5)});
    end
    chk("d3_if_rdata", d3_if_rdata, 32'd0);
    chk("d3_mem_wdata", d3_mem_wdata, 32'd0);

    // Every queued expectation must have been consumed
    tick();
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("ls_q_drained", 32'(ls_q.size()), 32'd0);
    chk("d3_q_drained", 32'(d3_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, SHALL set the number of consecutive cycles mem_en is held per access; legal range 1..7.
REQ-002 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-low reset; sampled on the CLK rising edge.
REQ-004 if_req  in  1  instruction-fetch read request; held high until if_gnt.
REQ-005 if_addr  in  32  fetch byte address; stable while if_req is high.
REQ-006 if_gnt  out  1  one-cycle pulse; fetch request accepted.
REQ-007 if_valid  out  1  one-cycle pulse; if_rdata carries read data.
REQ-008 if_rdata  out  32  fetch read data, registered.
REQ-009 ls_req  in  1  load/store request; held high until ls_gnt.
REQ-010 ls_we  in  1  1 = store, 0 = load.
REQ-011 ls_addr  in  32  load/store byte address.
REQ-012 ls_wdata  in  32  store data.
REQ-013 ls_gnt  out  1  one-cycle pulse; load/store request accepted.
REQ-014 ls_valid  out  1  one-cycle pulse; load data valid, or store acknowledged.
REQ-015 ls_rdata  out  32  load read data, registered.
REQ-016 mem_en  out  1  shared single-port data memory access enable.
REQ-017 mem_we  out  1  memory write enable; SHALL be high only with mem_en during a store.
REQ-018 mem_addr  out  32  latched byte address of the owning requester.
REQ-019 mem_wdata  out  32  latched store data.
REQ-020 mem_rdata  in  32  memory read data; valid in the cycle after the last mem_en cycle.
REQ-021 busy  out  1  high whenever the FSM state is not IDLE.

Function
REQ-022 The FSM SHALL have exactly four states: IDLE, ACCESS, WAIT and RESP.
REQ-023 IDLE: at a rising edge where rst=1 and either req is high, the FSM SHALL latch the owner, address, we and wdata, then enter ACCESS.
REQ-024 Owner latching SHALL use the winner from REQ-028; if_req always latches we=0.
REQ-025 ACCESS SHALL last exactly MEM_LAT cycles; during it mem_en=1 and mem_addr/mem_wdata/mem_we SHALL hold the latched values.
REQ-026 The owner's gnt SHALL be high only in the first ACCESS cycle.
REQ-027 Cycle accounting SHALL use a 3-bit counter that is loaded on entry to ACCESS and leaves ACCESS after MEM_LAT cycles.
REQ-028 Arbitration SHALL be round-robin: with a single request, that requester wins; with a tie, the requester not served last wins.
REQ-029 The last-served register SHALL reset to IF, so LS wins the first tie.
REQ-030 WAIT: mem_en=0; at the end of WAIT, for a load or fetch, the owner's rdata register SHALL load mem_rdata.
REQ-031 RESP: the owner's valid SHALL be 1 for exactly one cycle; the FSM then SHALL return to IDLE.
REQ-032 For a store, ls_valid SHALL still pulse in RESP, and ls_rdata SHALL stay unchanged.
REQ-033 rdata registers SHALL hold their values until the next read response to that port.
REQ-034 Latency SHALL be: req sampled at edge N gives gnt in cycle N+1, and valid in cycle N+MEM_LAT+2.
REQ-035 Throughput SHALL be one transaction per MEM_LAT+3 cycles.
REQ-036 Requests SHALL be sampled only in IDLE; a req dropped before its gnt SHALL be ignored without error.
REQ-037 A req still high at an IDLE edge after that requester's valid SHALL be treated as a new request.
REQ-038 Input changes outside IDLE SHALL NOT affect the mem_* outputs.
REQ-039 The arbiter SHALL NOT check address alignment; mem_addr SHALL equal the requester's address bit-exactly.

Reset
REQ-040 On a rising edge with rst=0, the FSM SHALL go to IDLE.
REQ-041 On that edge, all gnt, valid, mem_en, mem_we and busy outputs SHALL go to 0.
REQ-042 On that edge, mem_addr, mem_wdata, if_rdata and ls_rdata SHALL go to 0x00000000, and the counter SHALL go to 0.
REQ-043 On that edge, last-served SHALL go to IF.
REQ-044 Reset mid-transaction SHALL abandon the access: no valid pulse, and mem_en low from the next cycle.
REQ-045 Requests SHALL NOT be sampled on any edge where rst=0.

Verification
REQ-046 MEM_LAT=1, if_req with if_addr=0x00000008 at cycle 0, mem_rdata=0x8C250003 in cycle 2 -> if_gnt and mem_en in cycle 1; if_valid with if_rdata=0x8C250003 in cycle 3; busy low in cycle 4.
REQ-047 ls_req, ls_we=1, ls_addr=0x0C, ls_wdata=0x12345678 -> one mem_en cycle with mem_we=1, mem_addr=0x0C, mem_wdata=0x12345678; ls_valid two cycles later; ls_rdata unchanged.
REQ-048 Both req held continuously from reset -> grant order LS, IF, LS, IF, with exactly one transaction in flight per MEM_LAT+3 cycles.
REQ-049 MEM_LAT=3, single load -> mem_en high exactly 3 cycles, and ls_valid 5 cycles after the sampling edge.
REQ-050 rst=0 asserted in the ACCESS cycle of a load -> no ls_valid; all outputs at reset values on the next cycle; a fresh if_req is then served normally.
